// File: rtl/delay_var_pkg.sv
// ============================================================================
// delay_pkg : shared helpers for the runtime-configurable delay line
// Rev 1.0
// ============================================================================
`default_nettype none

package delay_pkg;

  // 0 maps to 1 and anything above the storage depth maps to the depth.
  function automatic int unsigned clamp_del(input int unsigned del,
                                            input int unsigned max_del);
    if (del == 0) return 1;
    if (del > max_del) return max_del;
    return del;
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_var.sv
// ============================================================================
// delay_var : delay line with runtime-selectable tap, valid tracking,
//             clock-enable stall, flush and a settle indicator
// Rev 1.0
// ============================================================================
`default_nettype none

module delay_var
  import delay_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int MAX_DEL = 16,
  localparam int DW      = $clog2(MAX_DEL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          flush,
  input  logic [DW-1:0] del,
  input  logic [W-1:0]  din,
  input  logic          din_vld,
  output logic [W-1:0]  dout,
  output logic          dout_vld,
  output logic          settled,
  output logic [DW-1:0] del_cur
);

  localparam int AW = (MAX_DEL > 1) ? $clog2(MAX_DEL) : 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic         vld;
  } stage_t;

  generate
    if (MAX_DEL < 1) begin : g_bad_max_del
      $error("delay_var: MAX_DEL must be >= 1");
    end
  endgenerate

  stage_t        stage_q [MAX_DEL];
  logic [DW-1:0] del_q, del_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] w_del_clamp;
  logic [AW-1:0] w_tap;

  assign w_del_clamp = DW'(clamp_del(int'(unsigned'(del)), MAX_DEL));

  always_comb begin
    del_d  = del_q;
    fill_d = fill_q;
    if (flush) begin
      del_d  = w_del_clamp;
      fill_d = '0;
    end else if (ce) begin
      // A new delay restarts the fill count so stale samples are never marked valid.
      if (w_del_clamp != del_q) begin
        del_d  = w_del_clamp;
        fill_d = '0;
      end else if (fill_q < del_q) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      del_q  <= DW'(1);
      fill_q <= '0;
    end else begin
      del_q  <= del_d;
      fill_q <= fill_d;
    end
  end

  // Flush clears only the valid bits; data stages keep their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEL; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < MAX_DEL; i++) stage_q[i].vld <= 1'b0;
    end else if (ce) begin
      stage_q[0] <= '{data: din, vld: din_vld};
      for (int i = 1; i < MAX_DEL; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign w_tap    = AW'(del_q - 1'b1);
  assign settled  = (fill_q == del_q);
  assign dout     = stage_q[w_tap].data;
  assign dout_vld = stage_q[w_tap].vld & settled;
  assign del_cur  = del_q;

endmodule

`default_nettype wire

// File: doc/delay_var.md
# delay_var

Runtime-configurable delay line with valid tracking, clock-enable stall and flush. It extends the fixed single-tap register delay used across the video/game pipeline, where sync, blanking and pixel data must be re-aligned after modules of different latency. Delay is selectable per run, 1..MAX_DEL cycles, without re-synthesis. A settle indicator tells downstream when output timing is trustworthy after a delay change.

## Interface
- W, 8: data width per sample (bundle multiple signals by concatenation)
- MAX_DEL, 16: maximum delay in ce-cycles; ≥1; equals number of storage stages
- DW, $clog2(MAX_DEL+1): width of delay select (localparam)
- clk  in  1  posedge clock
- rst  in  1  reset, synchronous, active-high; clock clk
- ce  in  1  clock enable; 0 freezes all state
- flush  in  1  synchronous clear of valid bits and settle counter; data stages untouched
- del  in  DW  requested delay; 0 treated as 1, >MAX_DEL treated as MAX_DEL
- din  in  W  input sample
- din_vld  in  1  input sample valid
- dout  out  W  delayed sample = stage[del_q-1]
- dout_vld  out  1  delayed valid, gated by settled
- settled  out  1  1 when current delay has been in force for ≥ del_q ce-cycles
- del_cur  out  DW  delay actually in force (del_q)

## Operation
- Storage: MAX_DEL stages of {data, vld}. On edge with ce=1: stage[0]<=din/din_vld, stage[i]<=stage[i-1].
- del_q: clamped copy of del, updated only on ce=1 edges.
- fill_cnt (DW bits): on ce=1 edge, if clamp(del)!=del_q → del_q<=clamp(del), fill_cnt<=0; else if fill_cnt<del_q → fill_cnt+1; saturates at del_q.
- settled = (fill_cnt==del_q), combinational from registers.
- dout = stage[del_q-1].data, combinational tap mux; dout_vld = stage[del_q-1].vld & settled.
- Delay change drops in-flight samples (dout_vld=0 for new del_q ce-cycles); no duplicated or reordered valid output ever.
- Priority per edge: rst > flush > ce. flush acts regardless of ce: all vld<=0, fill_cnt<=0, del_q<=clamp(del). ce=0 with no rst/flush: everything holds, outputs stable.
- Reset values: all stage data 0, all vld 0, del_q=1, fill_cnt=0 → dout=0, dout_vld=0, settled=0, del_cur=1.

## Timing
- Latency: with ce=1 continuously and settled, sample at din in cycle n appears at dout in cycle n+del_q (after del_q rising edges). del_q=1 behaves exactly as one register.
- With stalls: latency is del_q ce=1 edges; ce=0 cycles add no sample shift.
- After reset with constant del=D, ce=1: first edge sets del_q=D (if D≠1) and fill_cnt=0; settled rises after D further ce edges. With D=1: settled after 1 edge.
- del change takes effect at the next ce=1 edge; del_cur and dout tap switch in the following cycle; dout_vld low until settled.
- rst or flush asserted mid-stream: dout_vld low in the next cycle; data may show stale values (don't-care while vld=0).
- Simultaneous del change and flush: flush path, del_q takes new value, fill_cnt=0.
- No combinational path from din to dout; del affects dout only through del_q.

## Structure
- Package delay_pkg: function clamp_del(del, MAX_DEL), stage struct typedef {data, vld} parameterised via W in module (typedef local if W-dependent).
- Single module; tap mux inline. No sub-module needed; fill_cnt/del_q control may be a separate always_ff block in the same file.
- Parameter check: elaboration-time assertion MAX_DEL≥1.

## Test plan
- Reset: W=8, MAX_DEL=16, rst for 2 cycles → dout=0, dout_vld=0, settled=0, del_cur=1.
- Fixed delay: del=5, ce=1, din=ramp 0x00.., din_vld=1 → settled after 5 edges; dout in cycle n equals din of cycle n-5, dout_vld=1.
- Clamp: del=0 → del_cur=1; del=20 → del_cur=16; data latency matches.
- Stall: del=3, ce toggling 1,0,1,1,0,1 → outputs hold during ce=0; each sample emitted after exactly 3 ce=1 edges, none lost or duplicated.
- Delay change: settled at del=4, switch to del=2 → dout_vld=0 for 2 ce edges after switch, then din(n-2) with valid; no sample output twice; repeat 2→7.
- Flush/priority: flush mid-stream with ce=0 → dout_vld=0 next cycle, settled=0, recovers after del_q ce edges; rst and flush together → reset values.
